// File: rtl/nios_io_pkg.sv
// Shared constants and helpers for the nios board input conditioner.
package nios_io_pkg;

    localparam int unsigned N_BTN                   = 4;
    localparam int unsigned N_SW                    = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

    // Counter only needs to reach DEBOUNCE_CYCLES-1; clamp to at least one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input channel: 2-flop synchroniser, stability counter, accepted level and
// registered one-cycle rise/fall pulses aligned with the level change.
module debounce_bit
    import nios_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          RESET_VAL       = 1'b0
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned   CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            level_q <= RESET_VAL;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Any sample matching the accepted level restarts the stability window.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/nios_input_conditioner.sv
// Debounces board buttons and switches for the nios PIO inputs and derives
// press/release/change events plus a sticky write-1-to-clear press capture.
module nios_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = nios_io_pkg::DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned N_BTN           = nios_io_pkg::N_BTN,
    parameter int unsigned N_SW            = nios_io_pkg::N_SW
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [N_BTN-1:0] key_n,
    input  logic [N_SW-1:0]  sw,
    output logic [N_BTN-1:0] button_export,
    output logic [N_SW-1:0]  switch_export,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_changed,
    output logic [N_BTN-1:0] edge_capture,
    input  logic [N_BTN-1:0] edge_clear
);

    logic [N_BTN-1:0] key_level, key_rise, key_fall;
    logic [N_SW-1:0]  sw_level, sw_rise, sw_fall;
    logic [N_BTN-1:0] edge_capture_q, edge_capture_d;

    // Button pins idle high, so their channels reset to the released level.
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b1)
        ) u_debounce (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .din           (key_n[i]),
            .level         (key_level[i]),
            .rise          (key_rise[i]),
            .fall          (key_fall[i])
        );
    end

    for (genvar j = 0; j < N_SW; j++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b0)
        ) u_debounce (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .din           (sw[j]),
            .level         (sw_level[j]),
            .rise          (sw_rise[j]),
            .fall          (sw_fall[j])
        );
    end

    // Pin falling edge is a press once polarity is flipped.
    always_comb begin
        button_export = ~key_level;
        btn_press     = key_fall;
        btn_release   = key_rise;
        switch_export = sw_level;
        sw_changed    = sw_rise | sw_fall;
    end

    // Set wins over a simultaneous clear.
    always_comb begin
        edge_capture_d = (edge_capture_q & ~edge_clear) | btn_press;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            edge_capture_q <= '0;
        end else begin
            edge_capture_q <= edge_capture_d;
        end
    end

    assign edge_capture = edge_capture_q;

endmodule

// File: tb/tb_nios_input_conditioner.sv
// Scoreboard bench: a window-based reference model predicts every cycle's outputs,
// a separate monitor compares them on the falling clock edge.
module tb_nios_input_conditioner;

    localparam int unsigned D   = 4;
    localparam int unsigned NB  = 4;
    localparam int unsigned NS  = 10;
    localparam int unsigned NCH = NB + NS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] key_n = '1;
    logic [NS-1:0] sw = '0;
    logic [NB-1:0] edge_clear = '0;
    logic [NB-1:0] button_export, btn_press, btn_release, edge_capture;
    logic [NS-1:0] switch_export, sw_changed;

    always #5 clk = ~clk;

    nios_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .N_BTN           (NB),
        .N_SW            (NS)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .key_n         (key_n),
        .sw            (sw),
        .button_export (button_export),
        .switch_export (switch_export),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .sw_changed    (sw_changed),
        .edge_capture  (edge_capture),
        .edge_clear    (edge_clear)
    );

    typedef struct packed {
        logic [NB-1:0] btn;
        logic [NS-1:0] swl;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NS-1:0] chg;
        logic [NB-1:0] cap;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    // Reference model state: raw pin samples per channel and accepted pin level.
    bit            hist[NCH][$];
    bit            acc[NCH];
    logic [NB-1:0] m_cap;
    logic [NB-1:0] m_press_prev;

    function automatic bit pin_of(input int ch);
        return (ch < NB) ? key_n[ch] : sw[ch - NB];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            bit rv;
            rv = (c < NB);
            hist[c].delete();
            repeat (D + 2) hist[c].push_back(rv);
            acc[c] = rv;
        end
        m_cap        = '0;
        m_press_prev = '0;
    endtask

    // A new level is accepted once the last D synchronised samples (pins seen two
    // edges earlier) all disagree with the accepted level.
    task automatic model_step();
        exp_t          e;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NS-1:0] chg;
        press = '0;
        rel   = '0;
        chg   = '0;
        for (int c = 0; c < NCH; c++) begin
            bit all_diff;
            int sz;
            hist[c].push_back(pin_of(c));
            if (hist[c].size() > D + 3) void'(hist[c].pop_front());
            sz = hist[c].size();
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) begin
                if (hist[c][sz - 3 - k] == acc[c]) all_diff = 1'b0;
            end
            if (all_diff) begin
                acc[c] = ~acc[c];
                if (c < NB) begin
                    if (acc[c] == 1'b0) press[c] = 1'b1;
                    else                rel[c]   = 1'b1;
                end else begin
                    chg[c - NB] = 1'b1;
                end
            end
        end
        m_cap        = (m_cap & ~edge_clear) | m_press_prev;
        m_press_prev = press;
        for (int i = 0; i < NB; i++) e.btn[i] = ~acc[i];
        for (int j = 0; j < NS; j++) e.swl[j] = acc[NB + j];
        e.press = press;
        e.rel   = rel;
        e.chg   = chg;
        e.cap   = m_cap;
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                check("reset_button_export", 32'(button_export), 32'd0);
                check("reset_switch_export", 32'(switch_export), 32'd0);
                check("reset_events", 32'({btn_press, btn_release, sw_changed}), 32'd0);
                check("reset_edge_capture", 32'(edge_capture), 32'd0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("button_export", 32'(button_export), 32'(e.btn));
                check("switch_export", 32'(switch_export), 32'(e.swl));
                check("btn_press", 32'(btn_press), 32'(e.press));
                check("btn_release", 32'(btn_release), 32'(e.rel));
                check("sw_changed", 32'(sw_changed), 32'(e.chg));
                check("edge_capture", 32'(edge_capture), 32'(e.cap));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        cyc(22);

        // Clean press and release on button 0.
        key_n[0] = 1'b0;
        cyc(10);
        key_n[0] = 1'b1;
        cyc(10);

        // Bouncing button 1, then a clean settle low.
        for (int i = 0; i < 10; i++) begin
            key_n[1] = ~key_n[1];
            cyc(2);
        end
        key_n[1] = 1'b0;
        cyc(10);
        key_n[1] = 1'b1;
        cyc(10);

        // Continuous clear while button 2 is pressed.
        edge_clear[2] = 1'b1;
        key_n[2] = 1'b0;
        cyc(12);
        key_n[2] = 1'b1;
        cyc(8);
        edge_clear[2] = 1'b0;

        // Switch change and return.
        sw = 10'h201;
        cyc(10);
        sw = '0;
        cyc(10);

        // Reset in the middle of a count on button 3.
        key_n[3] = 1'b0;
        cyc(3);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(12);
        key_n[3] = 1'b1;
        cyc(10);

        // Switches held high through reset are loaded after the window.
        sw = '1;
        cyc(8);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(10);

        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 6) == 0) key_n[b] = ~key_n[b];
            end
            for (int s = 0; s < NS; s++) begin
                if ($urandom_range(0, 6) == 0) sw[s] = ~sw[s];
            end
            edge_clear = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
            end
            cyc(1);
        end
        cyc(5);

        if (compared < 1000) begin
            mismatched++;
            $display("FAIL too_few_comparisons: got %0d, expected at least 1000", compared);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/nios_input_conditioner.md
# nios_input_conditioner

Front-end conditioner for the board push-buttons and slide switches feeding the `nios` system's `button_external_connection_export[3:0]` and `switch_external_connection_export[9:0]` PIO inputs. Each pin is synchronised and debounced. Buttons are converted from active-low pins to active-high levels. The block also generates one-cycle press/release/change events and a sticky per-button edge-capture register for polled firmware or glue logic. It sits between the top-level pins and the `nios` instance.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: stable cycles required before accepting a new level (10 ms at 50 MHz); legal range ≥ 2.
- `N_BTN`, default 4: number of push-buttons.
- `N_SW`, default 10: number of slide switches.

Ports:
- `clk_clk`  in  1  system clock; single clock domain for the whole block.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  N_BTN  raw button pins, active-low, asynchronous to `clk_clk`.
- `sw`  in  N_SW  raw switch pins, asynchronous to `clk_clk`.
- `button_export`  out  N_BTN  debounced button level, active-high (1 = pressed); drives `button_external_connection_export`.
- `switch_export`  out  N_SW  debounced switch level; drives `switch_external_connection_export`.
- `btn_press`  out  N_BTN  one-cycle pulse when a button's debounced level goes 0→1.
- `btn_release`  out  N_BTN  one-cycle pulse when a button's debounced level goes 1→0.
- `sw_changed`  out  N_SW  one-cycle pulse on any debounced switch transition.
- `edge_capture`  out  N_BTN  sticky bit, set by `btn_press`.
- `edge_clear`  in  N_BTN  write-1-to-clear for `edge_capture`, sampled each cycle.

## Operation
Each of the N_BTN + N_SW inputs gets an independent bit channel:

- **Synchroniser:** 2-flop chain.
  - Button chains reset to 1 (released).
  - Switch chains reset to 0.
- **Level register `S`:** holds the accepted level.
  - Reset value: released for buttons (output 0), 0 for switches.
- **Counter `cnt`:** width `$clog2(DEBOUNCE_CYCLES)`, reset 0.
- **Per-cycle behaviour:**
  - Synchronised value == `S`: `cnt` <= 0.
  - Value != `S` and `cnt` < DEBOUNCE_CYCLES-1: `cnt` <= `cnt`+1.
  - Value != `S` and `cnt` == DEBOUNCE_CYCLES-1: `S` <= value, `cnt` <= 0, and the channel's event pulse fires in the same cycle `S` changes.
- **Glitch rejection:** any bounce back to `S` before expiry restarts the count from 0. The counter never wraps.
- **Button polarity:** `button_export` = ~`S` on the raw pin polarity.
  - `btn_press` fires when `button_export` rises.
  - `btn_release` fires when it falls.
- **Edge capture:** `edge_capture[i]` <= (`edge_capture[i]` & ~`edge_clear[i]`) | `btn_press[i]`.
  - A set and a clear in the same cycle leave the bit 1 (set wins).
  - Clearing an already-0 bit has no effect.
- **Reset behaviour:**
  - All outputs are 0 during reset.
  - Reset mid-count discards the count.
- **Post-reset settling:** a switch held at 1 through reset is accepted after the normal debounce window, and `sw_changed` pulses once at that point. Firmware relies on this event as the initial-state load.

## Timing
- Edge 0 is the first rising edge that samples a new, stable pin value into sync flop 1.
- Accepted level and event pulse appear after edge DEBOUNCE_CYCLES+1.
  - Example: with DEBOUNCE_CYCLES = 4, outputs update after edge 5.
- `edge_capture` sets one cycle after `btn_press` is asserted, i.e. after edge DEBOUNCE_CYCLES+2.
- `edge_clear` takes effect on the next edge.
- Minimum accepted pulse width on a pin is DEBOUNCE_CYCLES cycles. Shorter pulses produce no output change and no event.
- Channels are fully independent; simultaneous transitions on several pins produce simultaneous events.
- `btn_press` and `btn_release` are never high together on one channel.

## Structure
- Package `nios_io_pkg` holds:
  - `N_BTN`, `N_SW` and `DEBOUNCE_CYCLES_DEFAULT` constants.
  - A function computing the counter width.
- Sub-module `debounce_bit`:
  - Parameters: `DEBOUNCE_CYCLES`, `RESET_VAL`.
  - Ports: `clk_clk`, `reset_reset_n`, `din`, `level`, `rise`, `fall`.
  - Instantiated N_BTN + N_SW times via generate.
- The top level contains only button inversion, event mapping and the `edge_capture` register.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES = 4.
- **Reset defaults:** assert reset with `key_n`=4'hF, `sw`=0 → all outputs 0 during reset and 20 cycles after release; no events.
- **Clean press:** drive `key_n[0]`=0 at edge 0 and hold → `button_export[0]`=1 and `btn_press[0]` pulse after edge 5, then `edge_capture[0]`=1 after edge 6.
- **Bounce rejection:** `key_n[1]` toggles 0/1 every 2 cycles for 20 cycles, then holds 0 → exactly one `btn_press[1]`, 5 edges after the final settle.
- **Clear race:** hold `edge_clear[2]`=1 continuously while pressing button 2 → `edge_capture[2]` goes 1 on the set cycle (set wins), then 0 on the next edge.
- **Switch change:** `sw`=10'h201 held → `switch_export`=10'h201, `sw_changed`=10'h201 for one cycle; then release → `sw_changed` pulses again.
- **Reset mid-count:** `key_n[3]`=0 for 3 cycles, assert reset, release, keep pin 0 → no pulse before reset; press accepted 5 edges after the first post-reset sample.
